// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// status bit positions and FSM encodings. Optional macro: UART_PARITY_EN.
package mmio_uart_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_MSB   = 8;
    localparam int OVF_CLR_BIT  = 3;

    // The parity code exists only when the parity stage is built in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_e;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-bus view of the UART (A/WE/WD/RD, same bus as data memory) plus a
// debug tap of the transmitter FSM state.
interface mmio_uart_tx_if;
    import mmio_uart_pkg::*;

    // Single-cycle bus: a store takes effect at the clock edge where WE is high;
    // RD is a combinational function of A and has no handshake or wait states.
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    uart_state_e dbg_state;

    modport master (output WE, A, WD, input RD, dbg_state);
    modport slave  (input WE, A, WD, output RD, dbg_state);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serialiser. A push while full is
// accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS decode, sticky overflow flag and
// the serialising FSM. Define UART_PARITY_EN to add an even-parity bit (8E1).
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus_if,
    output logic          tx,
    output logic          busy
);

    localparam int            CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int            BW          = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLK_DIV - 1);
    localparam logic [31:0]   TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + STATUS_OFS;

    uart_state_e   state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          ovf_q;
`ifdef UART_PARITY_EN
    logic          par_q;
`endif

    logic             wr_txdata;
    logic             wr_status;
    logic             baud_last;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_rd;
    logic             unused_wd_hi;

    assign wr_txdata    = bus_if.WE && (bus_if.A == TXDATA_ADDR);
    assign wr_status    = bus_if.WE && (bus_if.A == STATUS_ADDR);
    assign baud_last    = (baud_q == BAUD_LAST);
    assign unused_wd_hi = ^bus_if.WD[31:8];

    // The next byte leaves the FIFO either from idle or on the final stop-bit
    // cycle, which is what makes back-to-back frames gapless.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_txdata),
        .pop_i   (fifo_pop),
        .din_i   (bus_if.WD[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (wr_status && bus_if.WD[OVF_CLR_BIT]) begin
            ovf_q <= 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
        end
    end

    always_comb begin
        status_rd = '0;
        if (bus_if.A == STATUS_ADDR) begin
            status_rd[ST_CNT_MSB:ST_CNT_LSB] = 5'(fifo_count);
            status_rd[ST_OVF_BIT]            = ovf_q;
            status_rd[ST_BUSY_BIT]           = busy;
            status_rd[ST_EMPTY_BIT]          = fifo_empty;
            status_rd[ST_FULL_BIT]           = fifo_full;
        end
    end

    assign bus_if.RD        = status_rd;
    assign bus_if.dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    if (fifo_pop) begin
                        shift_q   <= fifo_dout;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= ST_START;
`ifdef UART_PARITY_EN
                        par_q     <= even_parity(fifo_dout);
`endif
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            shift_q   <= fifo_dout;
                            bit_idx_q <= '0;
                            tx_q      <= 1'b0;
                            state_q   <= ST_START;
`ifdef UART_PARITY_EN
                            par_q     <= even_parity(fifo_dout);
`endif
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule
